// File: rtl/uio_arb_pkg.sv
// Shared types and helpers for the uio pad-bus arbiter.
//   arb_state_e : arbiter sequencing states
//   clog2       : elaboration-time ceiling log2 used to size counters/indices
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Handshake/bus bundle between the requesters, the pad bus and the arbiter.
//   req/wr/wdata : per-requester request, beat direction, write data (slice i = [i*DW +: DW])
//   gnt          : one-hot grant
//   bus_out/oe   : pad drive value and enable (all oe bits equal)
//   bus_in       : pad sample
//   rdata/rd_valid : registered read sample and one-hot valid
interface uio_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      bus_out;
  logic [DW-1:0]      bus_oe;
  logic [DW-1:0]      bus_in;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rd_valid;

  // requester/pad side
  modport master (
    output req, wr, wdata, bus_in,
    input  gnt, bus_out, bus_oe, rdata, rd_valid
  );

  // arbiter side
  modport slave (
    input  req, wr, wdata, bus_in,
    output gnt, bus_out, bus_oe, rdata, rd_valid
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index
//   any : at least one request set
//   idx : first set request at or after ptr, searching circularly
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [clog2(NREQ)-1:0]   ptr,
  output logic                     any,
  output logic [clog2(NREQ)-1:0]   idx
);
  localparam int IW = clog2(NREQ);

  logic [NREQ-1:0] req_rot;
  logic [IW:0]     sum;

  // Rotate so bit k of req_rot is requester (ptr+k) mod NREQ.
  assign req_rot = NREQ'({req, req} >> ptr);

  always_comb begin
    any = 1'b0;
    idx = '0;
    sum = '0;
    // Descending scan: the lowest rotated offset wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = {1'b0, ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        any = 1'b1;
        idx = sum[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared bidirectional uio pad bus.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : uio_bus_arbiter_if.slave (requests, grants, pad drive/sample, read return)
//
// state | meaning
// IDLE  | no owner; pick next requester at or after ptr
// TURN  | bus released, counting turnaround before ownership
// OWN   | owner granted; each cycle with its req high is one beat
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic             clk,
  input  logic             reset,
  uio_bus_arbiter_if.slave bus
);
  localparam int IW = clog2(NREQ);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int CW = 2;

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   bus_out_q, bus_out_d;
  logic            bus_oe_q, bus_oe_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] owner_oh;
  logic            own_req;
  logic            own_wr;
  logic [DW-1:0]   own_wdata;
  logic            beat;
  logic            last_beat;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_oh = NREQ'(1) << owner_q;
  assign own_req  = |(bus.req & owner_oh);
  assign own_wr   = |(bus.wr & owner_oh);

  always_comb begin
    own_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) own_wdata = bus.wdata[i*DW +: DW];
    end
  end

  assign beat      = (state_q == OWN) && own_req;
  assign last_beat = beat && (burst_q == BW'(MAX_BURST - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    bus_out_d  = bus_out_q;
    rdata_d    = rdata_q;
    bus_oe_d   = 1'b0;
    rd_valid_d = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = CW'(TURN_CYC - 1);
          state_d = TURN;
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = OWN;
          burst_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OWN: begin
        if (beat) begin
          burst_d = burst_q + BW'(1);
          if (own_wr) begin
            bus_out_d = own_wdata;
            bus_oe_d  = 1'b1;
          end else begin
            rdata_d    = bus.bus_in;
            rd_valid_d = owner_oh;
          end
        end
        // Release on a dropped request or once the burst cap is reached;
        // the following IDLE cycle doubles as the re-arbitration cycle.
        if (!own_req || last_beat) begin
          state_d = IDLE;
          ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      bus_out_q  <= '0;
      bus_oe_q   <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.gnt      = (state_q == OWN) ? owner_oh : '0;
  assign bus.bus_out  = bus_out_q;
  assign bus.bus_oe   = {DW{bus_oe_q}};
  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed testbench for uio_bus_arbiter (NREQ=4, DW=8, MAX_BURST=4, TURN_CYC=1).
// Cycle c of a scenario is the interval starting 1 time unit after the c-th
// rising edge following the scenario start; inputs change and outputs are
// sampled at that point.
module tb_uio_bus_arbiter;
  import uio_arb_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  uio_bus_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  uio_bus_arbiter #(
    .NREQ(4), .DW(8), .MAX_BURST(4), .TURN_CYC(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    bus.req = 4'b1111;
    bus.wr  = 4'b1111;
    do_reset();
    bus.req = 4'b0000;
    n_checks++; if (bus.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    n_checks++; if (bus.bus_oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe got=%h exp=00", bus.bus_oe); end
    n_checks++; if (bus.bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", bus.bus_out); end
    n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    n_checks++; if (bus.rd_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rdv got=%b exp=0000", bus.rd_valid); end
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr_q); end
  endtask

  task automatic test_single_write;
    logic [3:0] eg;
    logic [7:0] eoe;
    do_reset();
    bus.req   = 4'b0010;
    bus.wr    = 4'b0010;
    bus.wdata = 32'h0000_A500;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) bus.req = 4'b0000;
      eg  = (c >= 2 && c <= 5) ? 4'b0010 : 4'b0000;
      eoe = (c >= 3 && c <= 6) ? 8'hFF : 8'h00;
      n_checks++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL sw_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg); end
      n_checks++; if (bus.bus_oe !== eoe) begin n_fail++; $display("FAIL sw_oe c=%0d got=%h exp=%h", c, bus.bus_oe, eoe); end
      if (eoe == 8'hFF) begin
        n_checks++; if (bus.bus_out !== 8'hA5) begin n_fail++; $display("FAIL sw_out c=%0d got=%h exp=a5", c, bus.bus_out); end
      end
      if (c == 7) begin
        n_checks++; if (dut.ptr_q !== 2'd2) begin n_fail++; $display("FAIL sw_ptr got=%0d exp=2", dut.ptr_q); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin;
    int ph, k, drv;
    logic [3:0] eg;
    logic [7:0] eoe, eout;
    do_reset();
    bus.req   = 4'b1111;
    bus.wr    = 4'b1111;
    bus.wdata = 32'h4332_2110;
    // Each burst: IDLE, TURN, 4 OWN beats -> 6-cycle period, owners 0,1,2,3,0.
    for (int c = 0; c <= 30; c++) begin
      ph  = c % 6;
      k   = c / 6;
      eg  = (ph >= 2) ? 4'(1 << (k % 4)) : 4'b0000;
      eoe = ((ph >= 3) || (ph == 0 && c >= 6)) ? 8'hFF : 8'h00;
      drv = (ph == 0) ? (k - 1) % 4 : k % 4;
      eout = 8'(8'h10 + 8'h11 * drv);
      n_checks++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg); end
      n_checks++; if (bus.bus_oe !== eoe) begin n_fail++; $display("FAIL rr_oe c=%0d got=%h exp=%h", c, bus.bus_oe, eoe); end
      if (eoe == 8'hFF) begin
        n_checks++; if (bus.bus_out !== eout) begin n_fail++; $display("FAIL rr_out c=%0d got=%h exp=%h", c, bus.bus_out, eout); end
      end
      tick();
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_read;
    logic [3:0] erv;
    do_reset();
    bus.req = 4'b0100;
    bus.wr  = 4'b0000;
    for (int c = 0; c < 9; c++) begin
      if (c == 6) bus.req = 4'b0000;
      bus.bus_in = (c >= 2 && c <= 5) ? 8'h3C : 8'hC3;
      erv = (c >= 3 && c <= 6) ? 4'b0100 : 4'b0000;
      n_checks++; if (bus.rd_valid !== erv) begin n_fail++; $display("FAIL rd_valid c=%0d got=%b exp=%b", c, bus.rd_valid, erv); end
      n_checks++; if (bus.bus_oe !== 8'h00) begin n_fail++; $display("FAIL rd_oe c=%0d got=%h exp=00", c, bus.bus_oe); end
      if (erv != 4'b0000) begin
        n_checks++; if (bus.rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_data c=%0d got=%h exp=3c", c, bus.rdata); end
      end
      tick();
    end
  endtask

  task automatic test_early_release;
    logic [3:0] eg;
    logic [7:0] eoe;
    do_reset();
    bus.req   = 4'b1001;
    bus.wr    = 4'b1001;
    bus.wdata = 32'hD300_00E0;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) bus.req = 4'b1000;
      eg  = (c >= 2 && c <= 4) ? 4'b0001 : ((c >= 7) ? 4'b1000 : 4'b0000);
      eoe = (c == 3 || c == 4 || c == 8) ? 8'hFF : 8'h00;
      n_checks++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL er_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg); end
      n_checks++; if (bus.bus_oe !== eoe) begin n_fail++; $display("FAIL er_oe c=%0d got=%h exp=%h", c, bus.bus_oe, eoe); end
      if (c == 5) begin
        n_checks++; if (dut.ptr_q !== 2'd1) begin n_fail++; $display("FAIL er_ptr got=%0d exp=1", dut.ptr_q); end
      end
      if (c == 8) begin
        n_checks++; if (bus.bus_out !== 8'hD3) begin n_fail++; $display("FAIL er_out got=%h exp=d3", bus.bus_out); end
      end
      tick();
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_mixed;
    logic [7:0] eoe;
    logic [3:0] erv;
    do_reset();
    bus.req    = 4'b0001;
    bus.wdata  = 32'h0000_005A;
    bus.bus_in = 8'h77;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) bus.req = 4'b0000;
      bus.wr = (c == 2 || c == 4) ? 4'b0001 : 4'b0000;
      eoe = (c == 3 || c == 5) ? 8'hFF : 8'h00;
      erv = (c == 4 || c == 6) ? 4'b0001 : 4'b0000;
      n_checks++; if (bus.bus_oe !== eoe) begin n_fail++; $display("FAIL mx_oe c=%0d got=%h exp=%h", c, bus.bus_oe, eoe); end
      n_checks++; if (bus.rd_valid !== erv) begin n_fail++; $display("FAIL mx_rdv c=%0d got=%b exp=%b", c, bus.rd_valid, erv); end
      if (eoe == 8'hFF) begin
        n_checks++; if (bus.bus_out !== 8'h5A) begin n_fail++; $display("FAIL mx_out c=%0d got=%h exp=5a", c, bus.bus_out); end
      end
      if (erv != 4'b0000) begin
        n_checks++; if (bus.rdata !== 8'h77) begin n_fail++; $display("FAIL mx_rdata c=%0d got=%h exp=77", c, bus.rdata); end
      end
      tick();
    end
  endtask

  // Runs straight after test_mixed so ptr starts at 1; the aborted owner is 2.
  task automatic test_reset_mid_burst;
    logic [3:0] eg;
    bus.req   = 4'b0100;
    bus.wr    = 4'b0100;
    bus.wdata = 32'h0099_0000;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) reset = 1'b1;
      if (c == 4) begin
        reset   = 1'b0;
        bus.req = 4'b1111;
      end
      eg = (c == 2 || c == 3) ? 4'b0100 : ((c == 6) ? 4'b0001 : 4'b0000);
      n_checks++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL mb_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg); end
      if (c == 3) begin
        n_checks++; if (bus.bus_out !== 8'h99) begin n_fail++; $display("FAIL mb_out1 got=%h exp=99", bus.bus_out); end
      end
      if (c == 4) begin
        n_checks++; if (bus.bus_oe !== 8'h00) begin n_fail++; $display("FAIL mb_oe got=%h exp=00", bus.bus_oe); end
        n_checks++; if (bus.bus_out !== 8'h00) begin n_fail++; $display("FAIL mb_out got=%h exp=00", bus.bus_out); end
        n_checks++; if (bus.rd_valid !== 4'b0) begin n_fail++; $display("FAIL mb_rdv got=%b exp=0000", bus.rd_valid); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL mb_state got=%0d exp=%0d", dut.state_q, IDLE); end
        n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL mb_ptr got=%0d exp=0", dut.ptr_q); end
      end
      tick();
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.req    = '0;
    bus.wr     = '0;
    bus.wdata  = '0;
    bus.bus_in = '0;
    #2;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_early_release();
    test_mixed();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 8-bit bidirectional uio pad bus.
- Requesters include the free-running counter, the adder result path and future blocks; each either drives the bus or samples it.
- Owns uio_out/uio_oe, enforces a turnaround gap between owners, caps burst length and returns sampled read data to the current owner.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, bus width
MAX_BURST, 4, max beats per grant (1..15)
TURN_CYC, 1, idle cycles between grant decision and ownership (1..3)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset; the top derives it as reset = ~rst_n
req  in  NREQ  per-requester request, held until done
wr  in  NREQ  per-requester beat direction: 1=drive bus, 0=sample bus
wdata  in  NREQ*DW  per-requester write data, slice i = bits [i*DW +: DW]
gnt  out  NREQ  one-hot grant; a beat occurs when gnt[i]&req[i]
bus_out  out  DW  to uio_out
bus_oe  out  DW  to uio_oe, all bits equal
bus_in  in  DW  from uio_in
rdata  out  DW  registered sample of bus_in
rd_valid  out  NREQ  one-hot, rdata valid for that requester

Behaviour:
- Reset: one clock, reset is synchronous and active-high. At the next clk edge with reset=1: state=IDLE, ptr=0, owner=0, burst=0, gnt=0, bus_out=0, bus_oe=0, rdata=0, rd_valid=0. Reset mid-burst aborts the burst with no further beats.
- States: IDLE, TURN, OWN.
- IDLE: gnt=0.
  - If any req is high, latch owner = first set req at or after ptr (circular search), set cnt=TURN_CYC-1, go to TURN.
  - If no req is high, stay in IDLE.
- TURN: gnt=0. Decrement cnt; when cnt==0, go to OWN with burst=0.
- OWN: gnt[owner]=1, driven combinationally from the registered state and owner.
  - Beat: req[owner]=1 in an OWN cycle. Increment burst on each beat.
  - Release if req[owner]=0 in that cycle (no beat). Also release after the beat where burst reaches MAX_BURST.
  - On release: ptr=(owner+1) mod NREQ, go to IDLE. The IDLE cycle counts as no extra turnaround; the re-arbitration decision is made in that cycle.
- Write beat at cycle t: bus_out=wdata[owner] and bus_oe=all-ones at t+1.
- Any cycle without a write beat: bus_oe=0 at t+1. bus_out holds its last value.
- Read beat at cycle t: rdata=bus_in sampled at the edge ending t, and rd_valid[owner]=1, both visible during t+1. rd_valid is 0 in all other cycles.
- Direction may change beat-to-beat within a burst; bus_oe follows beat by beat.
- Pad-bus guarantees:
  - Between the last driven cycle of one owner and the first driven cycle of the next, bus_oe=0 for at least TURN_CYC+1 cycles.
  - Two requesters are never granted in the same cycle.
- Fairness: a continuously requesting requester is granted within (NREQ-1) bursts.
- A requester that drops req while in TURN still reaches OWN, then releases with zero beats.
- Requests from non-owners are ignored until re-arbitration.
- Width rules: burst is clog2(MAX_BURST+1) bits; ptr and owner are clog2(NREQ) bits; wrap is by explicit compare, never by overflow.

Decomposition:
- Package uio_arb_pkg: state enum (IDLE, TURN, OWN) and function clog2.
- Sub-module rr_pick: combinational, inputs req and ptr, outputs any and idx (first set bit at or after ptr, circular). Instantiated once.
- Top-level wiring: the pad top instantiates uio_bus_arbiter and connects bus_out/bus_oe/bus_in to uio_out/uio_oe/uio_in.

Test Plan:
- Reset then single write: req=0010, wr=0010, wdata[1]=0xA5 held, cycle 0.
  - gnt=0010 in cycles 2..5.
  - bus_out=0xA5, bus_oe=0xFF in cycles 3..6.
  - bus_oe=0 from cycle 7.
  - ptr=2 afterwards.
- Round-robin: req=1111 held.
  - Grant order 0,1,2,3,0.
  - Each grant lasts exactly 4 beats.
  - At least 2 cycles of bus_oe=0 between consecutive owners' driven cycles.
- Read: requester 2, wr=0, bus_in=0x3C during OWN.
  - rdata=0x3C and rd_valid=0100 one cycle after each beat.
  - rd_valid=0 otherwise.
- Early release: requester 0 drops req after 2 beats.
  - gnt drops the next cycle.
  - Requester 3, which was waiting, is granted at the next arbitration (ptr=1, searching 1,2,3).
- Mixed direction: owner alternates wr=1,0,1,0.
  - bus_oe toggles 0xFF,0,0xFF,0 delayed one cycle.
  - rd_valid is set only after the read beats.
- Reset mid-burst: assert reset at the second beat.
  - Next cycle: gnt=0, bus_oe=0, rd_valid=0, state IDLE.
  - After reset release with req=1111, requester 0 is granted first.
